// File: rtl/ic_pkg.sv
// Shared definitions for the N-way instruction-cache tag/lookup stage.
// Holds the fill FSM state encoding and parameter helper functions.
package ic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEMR = 3'd1,
        ST_ICWT = 3'd2,
        ST_ICW2 = 3'd3,
        ST_ICW3 = 3'd4,
        ST_LDRD = 3'd5,
        ST_ERR  = 3'd6
    } ic_state_t;

    function automatic bit ic_nway_ok(input int n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

    function automatic int ic_way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ic_plru_bits(input int n);
        return (n == 4) ? 3 : 1;
    endfunction

endpackage

// File: rtl/ic_plru.sv
// Per-set replacement state: LRU bit (2-way) or tree PLRU (4-way).
// Ports: i_rd_set -> o_victim; i_upd/i_upd_set/i_upd_way mark a way MRU.
module ic_plru
    import ic_pkg::*;
#(
    parameter int NWAY = 2,
    parameter int SW   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic [SW-1:0]                i_rd_set,
    output logic [ic_way_bits(NWAY)-1:0] o_victim,
    input  logic                         i_upd,
    input  logic [SW-1:0]                i_upd_set,
    input  logic [ic_way_bits(NWAY)-1:0] i_upd_way
);

    localparam int PB   = ic_plru_bits(NWAY);
    localparam int NSET = 1 << SW;

    logic [PB-1:0] r_st [NSET];
    logic [PB-1:0] w_cur;
    logic [PB-1:0] w_nxt;

    assign w_cur = r_st[i_rd_set];

    if (NWAY == 4) begin : g_p4
        // bit0 picks the pair, bit1/bit2 pick within the left/right pair;
        // every bit points away from the most recently used side.
        logic [2:0] w_old;
        assign w_old = r_st[i_upd_set];
        always_comb begin
            o_victim = w_cur[0] ? {1'b1, w_cur[2]} : {1'b0, w_cur[1]};
            w_nxt    = w_old;
            w_nxt[0] = ~i_upd_way[1];
            if (i_upd_way[1]) begin
                w_nxt[2] = ~i_upd_way[0];
            end else begin
                w_nxt[1] = ~i_upd_way[0];
            end
        end
    end else if (NWAY == 2) begin : g_p2
        always_comb begin
            o_victim = w_cur;
            w_nxt    = ~i_upd_way;
        end
    end else begin : g_p1
        always_comb begin
            o_victim = '0;
            w_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            for (int s = 0; s < NSET; s++) begin
                r_st[s] <= '0;
            end
        end else if (i_upd) begin
            r_st[i_upd_set] <= w_nxt;
        end
    end

endmodule

// File: rtl/ic_tag_1r1w.sv
// One way of tag storage: synchronous read port, one write port.
// Ports: i_raddr/o_rdata (1-cycle read), i_we/i_waddr/i_wdata (write).
module ic_tag_1r1w #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [1 << AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ilu_stage_nway.sv
// N-way I-cache tag lookup stage with miss/fill/error control FSM.
// Ports: pc_if/pc_valid_id lookup; rst_pipe, start_icflush control;
// ic_rdat_m_valid/err fill return; hit/stall/fin/err status; fill request.
module ilu_stage_nway
    import ic_pkg::*;
#(
    parameter int IWIDTH = 14,
    parameter int NWAY   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:2]                  pc_if,
    input  logic                         pc_valid_id,
    input  logic                         rst_pipe,
    input  logic                         start_icflush,
    input  logic                         ic_rdat_m_valid,
    input  logic                         ic_rdat_m_err,
    output logic                         ic_tag_hit_id,
    output logic [ic_way_bits(NWAY)-1:0] ic_hit_way_id,
    output logic                         ic_stall,
    output logic                         ic_stall_fin,
    output logic                         ic_stall_fin2,
    output logic                         ic_fetch_err_id,
    output logic                         icr_start_rq,
    output logic [31:0]                  ic_rin_addr,
    output logic [IWIDTH-3:0]            ic_ram_wadr_all,
    output logic [ic_way_bits(NWAY)-1:0] ic_fill_way
);

    localparam int SW   = IWIDTH - 2;
    localparam int TW   = 26 - IWIDTH;
    localparam int WB   = ic_way_bits(NWAY);
    localparam int NSET = 1 << SW;

    if (!ic_nway_ok(NWAY)) begin : g_bad_nway
        $error("ilu_stage_nway: NWAY must be 1, 2 or 4");
    end

    ic_state_t       r_state;
    ic_state_t       w_state_nxt;
    logic [31:2]     r_pc_id;
    logic [31:0]     r_keeper;
    logic [NWAY-1:0] r_valid [NSET];
    logic [WB-1:0]   r_victim;
    logic            r_rq;
    logic            r_flush_sup;

    logic [SW-1:0]   w_idx_if;
    logic [SW-1:0]   w_idx_id;
    logic [SW-1:0]   w_idx_kp;
    logic [SW-1:0]   w_ridx;
    logic [TW-1:0]   w_tag_id;
    logic [TW-1:0]   w_tag_kp;
    logic [TW-1:0]   w_rtag [NWAY];
    logic [NWAY-1:0] w_vld;
    logic [NWAY-1:0] w_match;
    logic [WB-1:0]   w_hway;
    logic            w_inv_any;
    logic [WB-1:0]   w_inv_way;
    logic [WB-1:0]   w_plru_vict;
    logic [WB-1:0]   w_vict;
    logic            w_any;
    logic            w_miss;
    logic            w_busy;
    logic            w_hold;
    logic            w_start;
    logic            w_fill_we;
    logic            w_upd;
    logic [SW-1:0]   w_upd_set;
    logic [WB-1:0]   w_upd_way;

    assign w_idx_if = pc_if[IWIDTH+1:4];
    assign w_idx_id = r_pc_id[IWIDTH+1:4];
    assign w_tag_id = r_pc_id[27:IWIDTH+2];
    assign w_idx_kp = r_keeper[IWIDTH+1:4];
    assign w_tag_kp = r_keeper[27:IWIDTH+2];

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_LDRD);
    assign w_hold = ic_stall || ic_stall_fin;

    // While the fill runs the tag RAMs keep re-reading the miss set so
    // the refill is visible in ID; a stalled IDLE re-reads the ID set.
    assign w_ridx = w_busy ? w_idx_kp : (w_hold ? w_idx_id : w_idx_if);

    assign w_fill_we = (r_state == ST_MEMR) && ic_rdat_m_valid
                    && !ic_rdat_m_err && !r_flush_sup && !start_icflush;

    for (genvar g = 0; g < NWAY; g++) begin : g_way
        ic_tag_1r1w #(
            .AW(SW),
            .DW(TW)
        ) u_tag (
            .clk     (clk),
            .i_raddr (w_ridx),
            .o_rdata (w_rtag[g]),
            .i_we    (w_fill_we && (r_victim == WB'(g))),
            .i_waddr (w_idx_kp),
            .i_wdata (w_tag_kp)
        );
    end

    assign w_vld = r_valid[w_idx_id];

    always_comb begin
        w_match   = '0;
        w_hway    = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = 0; w < NWAY; w++) begin
            w_match[w] = w_vld[w] && (w_rtag[w] == w_tag_id);
        end
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hway = WB'(w);
            end
            if (!w_vld[w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WB'(w);
            end
        end
    end

    assign w_any   = |w_match;
    assign w_miss  = pc_valid_id && !w_any;
    assign w_vict  = w_inv_any ? w_inv_way : w_plru_vict;
    assign w_start = (r_state == ST_IDLE) && w_miss;

    assign w_upd     = w_fill_we || ic_tag_hit_id;
    assign w_upd_set = w_fill_we ? w_idx_kp : w_idx_id;
    assign w_upd_way = w_fill_we ? r_victim : w_hway;

    ic_plru #(
        .NWAY(NWAY),
        .SW  (SW)
    ) u_plru (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (rst_pipe),
        .i_rd_set  (w_idx_id),
        .o_victim  (w_plru_vict),
        .i_upd     (w_upd),
        .i_upd_set (w_upd_set),
        .i_upd_way (w_upd_way)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_miss) w_state_nxt = ST_MEMR;
            ST_MEMR: begin
                if (ic_rdat_m_valid) begin
                    w_state_nxt = ic_rdat_m_err ? ST_ERR : ST_ICWT;
                end
            end
            ST_ICWT: w_state_nxt = ST_ICW2;
            ST_ICW2: w_state_nxt = ST_ICW3;
            ST_ICW3: w_state_nxt = ST_LDRD;
            ST_LDRD: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || rst_pipe) begin
            r_state     <= ST_IDLE;
            r_pc_id     <= '0;
            r_keeper    <= '0;
            r_victim    <= '0;
            r_rq        <= 1'b0;
            r_flush_sup <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rq    <= w_start;
            if (!w_hold) begin
                r_pc_id <= pc_if;
            end
            if (w_start) begin
                r_keeper <= {r_pc_id, 2'b00};
                r_victim <= w_vict;
            end
            // A flush seen while waiting for the fill kills that fill's
            // tag/valid write when it finally returns.
            r_flush_sup <= (r_state == ST_MEMR) && !ic_rdat_m_valid
                        && (r_flush_sup || start_icflush);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || rst_pipe || start_icflush) begin
            for (int s = 0; s < NSET; s++) begin
                r_valid[s] <= '0;
            end
        end else if (w_fill_we) begin
            r_valid[w_idx_kp][r_victim] <= 1'b1;
        end
    end

    assign ic_tag_hit_id   = pc_valid_id && w_any;
    assign ic_hit_way_id   = ic_tag_hit_id ? w_hway : '0;
    assign ic_stall        = w_busy || (w_miss && (r_state != ST_LDRD));
    assign ic_stall_fin    = (r_state == ST_ICW3);
    assign ic_stall_fin2   = (r_state == ST_LDRD);
    assign ic_fetch_err_id = (r_state == ST_ERR);
    assign icr_start_rq    = r_rq;
    assign ic_rin_addr     = r_keeper;
    assign ic_ram_wadr_all = w_idx_kp;
    assign ic_fill_way     = r_victim;

endmodule

// File: tb/tb_ilu_stage_nway.sv
// Directed bench for ilu_stage_nway: 2-way and 4-way instances.
// Scenarios: reset, cold miss, conflict, flush, bus error, rst_pipe/rst_n, 4-way PLRU.
module tb_ilu_stage_nway;

    logic        clk = 1'b0;
    logic        rstn, pv, rdv, rde, flush, rpipe, sel4;
    logic [31:0] pc;
    int          checks = 0;
    int          errors = 0;

    logic        h2, st2, f2, ff2, e2, rq2;
    logic [0:0]  hw2, fw2;
    logic [31:0] ra2;
    logic [11:0] wa2;
    logic        h4, st4, f4, ff4, e4, rq4;
    logic [1:0]  hw4, fw4;
    logic [31:0] ra4;
    logic [11:0] wa4;

    logic        hit, stall, fin, fin2, ferr, rq;
    logic [1:0]  hway, fway;
    logic [31:0] rin;
    logic [11:0] wadr;

    always #5 clk = ~clk;

    ilu_stage_nway #(.IWIDTH(14), .NWAY(2)) u2 (
        .clk(clk), .rst_n(rstn), .pc_if(pc[31:2]), .pc_valid_id(pv & ~sel4),
        .rst_pipe(rpipe), .start_icflush(flush),
        .ic_rdat_m_valid(rdv), .ic_rdat_m_err(rde),
        .ic_tag_hit_id(h2), .ic_hit_way_id(hw2), .ic_stall(st2),
        .ic_stall_fin(f2), .ic_stall_fin2(ff2), .ic_fetch_err_id(e2),
        .icr_start_rq(rq2), .ic_rin_addr(ra2), .ic_ram_wadr_all(wa2),
        .ic_fill_way(fw2)
    );

    ilu_stage_nway #(.IWIDTH(14), .NWAY(4)) u4 (
        .clk(clk), .rst_n(rstn), .pc_if(pc[31:2]), .pc_valid_id(pv & sel4),
        .rst_pipe(rpipe), .start_icflush(flush),
        .ic_rdat_m_valid(rdv), .ic_rdat_m_err(rde),
        .ic_tag_hit_id(h4), .ic_hit_way_id(hw4), .ic_stall(st4),
        .ic_stall_fin(f4), .ic_stall_fin2(ff4), .ic_fetch_err_id(e4),
        .icr_start_rq(rq4), .ic_rin_addr(ra4), .ic_ram_wadr_all(wa4),
        .ic_fill_way(fw4)
    );

    assign hit   = sel4 ? h4  : h2;
    assign stall = sel4 ? st4 : st2;
    assign fin   = sel4 ? f4  : f2;
    assign fin2  = sel4 ? ff4 : ff2;
    assign ferr  = sel4 ? e4  : e2;
    assign rq    = sel4 ? rq4 : rq2;
    assign hway  = sel4 ? hw4 : {1'b0, hw2};
    assign fway  = sel4 ? fw4 : {1'b0, fw2};
    assign rin   = sel4 ? ra4 : ra2;
    assign wadr  = sel4 ? wa4 : wa2;

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Full miss/fill sequence for address a, expecting fill way ew.
    task automatic fill(input logic [31:0] a, input logic [1:0] ew, input string nm);
        pc = a; pv = 1'b0; go();
        pv = 1'b1; @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_miss_stall got %b exp 1", nm, stall); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL %s_miss_hit got %b exp 0", nm, hit); end
        go(); @(negedge clk);
        checks++; if (rq !== 1'b1) begin errors++; $display("FAIL %s_rq got %b exp 1", nm, rq); end
        checks++; if (rin !== a) begin errors++; $display("FAIL %s_rin got %h exp %h", nm, rin, a); end
        checks++; if (wadr !== a[15:4]) begin errors++; $display("FAIL %s_wadr got %h exp %h", nm, wadr, a[15:4]); end
        checks++; if (fway !== ew) begin errors++; $display("FAIL %s_fway got %0d exp %0d", nm, fway, ew); end
        go(); rdv = 1'b1; @(negedge clk);
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL %s_rq_once got %b exp 0", nm, rq); end
        go(); rdv = 1'b0; go(); go(); @(negedge clk);
        checks++; if ({fin, fin2} !== 2'b10) begin errors++; $display("FAIL %s_icw3 got %b exp 10", nm, {fin, fin2}); end
        go(); @(negedge clk);
        checks++; if ({fin, fin2, stall} !== 3'b010) begin errors++; $display("FAIL %s_ldrd got %b exp 010", nm, {fin, fin2, stall}); end
        checks++; if ({hit, hway} !== {1'b1, ew}) begin errors++; $display("FAIL %s_ldrd_hit got %b exp %b", nm, {hit, hway}, {1'b1, ew}); end
        go(); pv = 1'b0;
    endtask

    // Present one fetch; keep it valid through the edge only on a hit.
    task automatic probe(input logic [31:0] a, input logic eh, input logic [1:0] ew, input string nm);
        pc = a; pv = 1'b0; go();
        pv = 1'b1; @(negedge clk);
        checks++; if ({hit, hway} !== {eh, ew}) begin errors++; $display("FAIL %s_hit got %b exp %b", nm, {hit, hway}, {eh, ew}); end
        checks++; if (stall !== ~eh) begin errors++; $display("FAIL %s_stall got %b exp %b", nm, stall, ~eh); end
        pv = eh; go(); pv = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; pv = 1'b0; rdv = 1'b0; rde = 1'b0;
        flush = 1'b0; rpipe = 1'b0; sel4 = 1'b0; pc = 32'h0;
        go(); go(); go(); @(negedge clk);
        checks++; if ({hit, stall, fin, fin2, ferr, rq} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b exp 0", {hit, stall, fin, fin2, ferr, rq}); end
        checks++; if ({rin, wadr, hway, fway} !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", {rin, wadr, hway, fway}); end
        go(); rstn = 1'b1; go();
    endtask

    task automatic test_cold_miss();
        fill(32'h0000_1230, 2'd0, "cold");
        probe(32'h0000_1230, 1'b1, 2'd0, "cold_rehit");
    endtask

    task automatic test_conflict();
        fill(32'h0001_0230, 2'd0, "conf_a");
        fill(32'h0002_0230, 2'd1, "conf_b");
        probe(32'h0001_0230, 1'b1, 2'd0, "conf_touch_a");
        fill(32'h0003_0230, 2'd1, "conf_lru");
        probe(32'h0002_0230, 1'b0, 2'd0, "conf_evicted");
        probe(32'h0001_0230, 1'b1, 2'd0, "conf_a_kept");
    endtask

    task automatic test_flush();
        pc = 32'h0000_7770; pv = 1'b0; go();
        pv = 1'b1; go();
        flush = 1'b1; go(); flush = 1'b0;
        rdv = 1'b1; go(); rdv = 1'b0;
        go(); go(); go(); @(negedge clk);
        checks++; if ({fin2, hit} !== 2'b10) begin errors++; $display("FAIL flush_ldrd got %b exp 10", {fin2, hit}); end
        pv = 1'b0; go();
        probe(32'h0000_7770, 1'b0, 2'd0, "flush_addr");
        probe(32'h0000_1230, 1'b0, 2'd0, "flush_old1");
        probe(32'h0001_0230, 1'b0, 2'd0, "flush_old2");
        fill(32'h0000_1230, 2'd0, "refill");
        pc = 32'h0000_AAA0; pv = 1'b0; go();
        pv = 1'b1; go();
        flush = 1'b1; rdv = 1'b1; go(); flush = 1'b0; rdv = 1'b0;
        go(); go(); go(); @(negedge clk);
        checks++; if ({fin2, hit} !== 2'b10) begin errors++; $display("FAIL flush_same_ldrd got %b exp 10", {fin2, hit}); end
        pv = 1'b0; go();
        probe(32'h0000_1230, 1'b0, 2'd0, "flush_same_old");
    endtask

    task automatic test_bus_error();
        pc = 32'h0000_4560; pv = 1'b0; go();
        pv = 1'b1; go();
        rdv = 1'b1; rde = 1'b1; go(); rdv = 1'b0; rde = 1'b0; @(negedge clk);
        checks++; if ({ferr, stall} !== 2'b11) begin errors++; $display("FAIL err_state got %b exp 11", {ferr, stall}); end
        go(); @(negedge clk);
        checks++; if ({ferr, hit, stall} !== 3'b001) begin errors++; $display("FAIL err_refetch got %b exp 001", {ferr, hit, stall}); end
        go(); @(negedge clk);
        checks++; if (rq !== 1'b1) begin errors++; $display("FAIL err_rerq got %b exp 1", rq); end
        pv = 1'b0; rpipe = 1'b1; go(); rpipe = 1'b0;
    endtask

    task automatic test_rst_pipe();
        pc = 32'h0000_8880; pv = 1'b0; go();
        pv = 1'b1; go();
        rdv = 1'b1; go(); rdv = 1'b0; go();
        rpipe = 1'b1; pv = 1'b0; @(negedge clk);
        checks++; if ({stall, fin} !== 2'b10) begin errors++; $display("FAIL rp_icw2 got %b exp 10", {stall, fin}); end
        go(); rpipe = 1'b0; @(negedge clk);
        checks++; if ({stall, fin, fin2} !== 3'b000) begin errors++; $display("FAIL rp_idle got %b exp 000", {stall, fin, fin2}); end
        checks++; if (rin !== 32'h0) begin errors++; $display("FAIL rp_keeper got %h exp 0", rin); end
        probe(32'h0000_8880, 1'b0, 2'd0, "rp_cleared");
        pc = 32'h0000_9990; pv = 1'b0; go();
        pv = 1'b1; go(); @(negedge clk);
        checks++; if ({rq, rin} !== {1'b1, 32'h0000_9990}) begin errors++; $display("FAIL rn_memr got %h exp 1_00009990", {rq, rin}); end
        rstn = 1'b0; pv = 1'b0; go(); @(negedge clk);
        checks++; if ({hit, stall, fin, fin2, ferr, rq} !== 6'b0) begin errors++; $display("FAIL rn_flags got %b exp 0", {hit, stall, fin, fin2, ferr, rq}); end
        checks++; if ({rin, wadr, hway, fway} !== '0) begin errors++; $display("FAIL rn_data got %h exp 0", {rin, wadr, hway, fway}); end
        rstn = 1'b1; go();
    endtask

    task automatic test_nway4_plru();
        sel4 = 1'b1; go();
        fill(32'h0001_0230, 2'd0, "w4_f0");
        fill(32'h0002_0230, 2'd1, "w4_f1");
        fill(32'h0003_0230, 2'd2, "w4_f2");
        fill(32'h0004_0230, 2'd3, "w4_f3");
        probe(32'h0001_0230, 1'b1, 2'd0, "w4_t0");
        probe(32'h0003_0230, 1'b1, 2'd2, "w4_t2");
        fill(32'h0005_0230, 2'd1, "w4_plru");
        probe(32'h0004_0230, 1'b1, 2'd3, "w4_keep3");
        sel4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush();
        test_bus_error();
        test_rst_pipe();
        test_nway4_plru();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
